// File: rtl/sdm_pkg.sv
// Shared types and arithmetic helpers for the second-order delta-sigma DAC modulator.
package sdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Full-scale feedback magnitude for a DW-bit signed sample.
    function automatic logic signed [63:0] fs_of(input int dw);
        return 64'sd1 <<< (dw - 1);
    endfunction

    // Input limit that keeps the second-order loop stable.
    function automatic logic signed [63:0] xmax_of(input int dw);
        return (fs_of(dw) * 64'sd3) >>> 2;
    endfunction

    // Three-operand add clamped to a w-bit signed range.
    function automatic logic signed [63:0] sat_add3(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input logic signed [63:0] c,
        input int                 w
    );
        logic signed [63:0] sum;
        logic signed [63:0] lim_hi;
        logic signed [63:0] lim_lo;
        sum    = a + b + c;
        lim_hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lim_lo = -(64'sd1 <<< (w - 1));
        if (sum > lim_hi) begin
            return lim_hi;
        end else if (sum < lim_lo) begin
            return lim_lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sdm2_core.sv
// Two saturating integrators, 1-bit quantizer and +/-FS feedback; one step per update.
module sdm2_core
    import sdm_pkg::*;
#(
    parameter int DW = 16,
    parameter int IW = DW + 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          update,
    input  logic [DW-1:0] x,
    output logic          dout
);

    localparam logic signed [63:0] FS = fs_of(DW);

    logic signed [IW-1:0] acc1_reg;
    logic signed [IW-1:0] acc2_reg;
    logic signed [IW-1:0] acc1_next;
    logic signed [IW-1:0] acc2_next;
    logic                 dout_reg;
    logic                 dout_next;
    logic signed [63:0]   fb;
    logic signed [63:0]   sum1;
    logic signed [63:0]   sum2;

    // The second integrator sees the freshly updated first integrator.
    always_comb begin
        fb        = dout_reg ? FS : -FS;
        sum1      = sat_add3(64'(acc1_reg), 64'($signed(x)), -fb, IW);
        acc1_next = sum1[IW-1:0];
        sum2      = sat_add3(64'(acc2_reg), 64'(acc1_next), -fb, IW);
        acc2_next = sum2[IW-1:0];
        dout_next = ~acc2_next[IW-1];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc1_reg <= '0;
            acc2_reg <= '0;
            dout_reg <= 1'b0;
        end else if (update) begin
            acc1_reg <= acc1_next;
            acc2_reg <= acc2_next;
            dout_reg <= dout_next;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/sdm2_dac_modulator.sv
// Sample handshake, OSR frame counter, input clamping and sticky status around sdm2_core.
module sdm2_dac_modulator
    import sdm_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OSR = 256,
    parameter int IW  = DW + 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          dout,
    output logic          bit_valid,
    output logic          frame,
    output logic          clamp_flag,
    output logic          underrun_flag
);

    localparam int                    CW       = $clog2(OSR);
    localparam logic [CW-1:0]         CNT_LAST = CW'(OSR - 1);
    localparam logic signed [DW-1:0]  XMAX     = DW'(xmax_of(DW));

    state_t               state_reg;
    state_t               state_next;
    logic [CW-1:0]        cnt_reg;
    logic signed [DW-1:0] x_reg;
    logic signed [DW-1:0] x_clamped;
    logic signed [DW-1:0] din_s;
    logic                 clamp_hit;
    logic                 bit_valid_reg;
    logic                 frame_reg;
    logic                 clamp_flag_reg;
    logic                 underrun_flag_reg;
    logic                 at_wrap;
    logic                 run_update;
    logic                 accept;
    logic                 core_clear;

    assign at_wrap = (cnt_reg == CNT_LAST);

    always_comb begin
        din_s     = $signed(din);
        x_clamped = din_s;
        clamp_hit = 1'b0;
        if (din_s > XMAX) begin
            x_clamped = XMAX;
            clamp_hit = 1'b1;
        end else if (din_s < -XMAX) begin
            x_clamped = -XMAX;
            clamp_hit = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        din_ready  = 1'b0;
        run_update = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                din_ready = 1'b1;
                if (!en) begin
                    state_next = IDLE;
                end else if (din_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                din_ready = at_wrap;
                if (en) begin
                    run_update = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept     = din_ready & din_valid;
    assign core_clear = (state_next == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg           <= '0;
            x_reg             <= '0;
            bit_valid_reg     <= 1'b0;
            frame_reg         <= 1'b0;
            clamp_flag_reg    <= 1'b0;
            underrun_flag_reg <= 1'b0;
        end else begin
            if (accept) begin
                x_reg <= x_clamped;
                if (clamp_hit) begin
                    clamp_flag_reg <= 1'b1;
                end
            end
            if (state_reg != RUN) begin
                cnt_reg <= '0;
            end else if (run_update) begin
                cnt_reg <= at_wrap ? '0 : cnt_reg + CW'(1);
            end
            // Missing sample at a frame boundary: keep running on the previous x.
            if (run_update && at_wrap && !din_valid) begin
                underrun_flag_reg <= 1'b1;
            end
            bit_valid_reg <= run_update;
            frame_reg     <= run_update && (cnt_reg == '0);
        end
    end

    sdm2_core #(
        .DW (DW),
        .IW (IW)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clear  (core_clear),
        .update (run_update),
        .x      (x_reg),
        .dout   (dout)
    );

    assign bit_valid     = bit_valid_reg;
    assign frame         = frame_reg;
    assign clamp_flag    = clamp_flag_reg;
    assign underrun_flag = underrun_flag_reg;

endmodule

// File: tb/tb_sdm2_dac_modulator.sv
// Scoreboard bench: each accepted sample (or underrun) queues a frame of expected bits.
module tb_sdm2_dac_modulator;

    localparam int    DW   = 16;
    localparam int    OSR  = 256;
    localparam int    IW   = DW + 4;
    localparam longint FS   = 64'sd1 <<< (DW - 1);
    localparam longint XMAX = (FS * 3) / 4;
    localparam longint AMAX = (64'sd1 <<< (IW - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (IW - 1));
    localparam int    TOL  = 3;
    localparam int    S_IDLE = 0;
    localparam int    S_LOAD = 1;
    localparam int    S_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          dout;
    logic          bit_valid;
    logic          frame;
    logic          clamp_flag;
    logic          underrun_flag;

    sdm2_dac_modulator #(
        .DW  (DW),
        .OSR (OSR),
        .IW  (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dout          (dout),
        .bit_valid     (bit_valid),
        .frame         (frame),
        .clamp_flag    (clamp_flag),
        .underrun_flag (underrun_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    typedef struct {
        bit     b;
        bit     f;
        longint x;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   e;
    int     m_state = S_IDLE;
    int     mcnt = 0;
    longint mx = 0;
    longint m_a1 = 0;
    longint m_a2 = 0;
    bit     m_q = 0;
    bit     m_clamp = 0;
    bit     m_under = 0;
    bit     m_bv = 0;
    bit     m_clr = 0;
    bit     chk_on = 0;
    bit     cur_dout = 0;
    bit     cur_frame = 0;
    bit     m_ready;
    bit     m_acc;
    int     f_bits = 0;
    int     f_ones = 0;
    longint f_x = 0;
    longint prev_x = -1;
    longint ctr;
    longint a_peak = 0;
    longint a_now;

    function automatic longint sat_iw(input longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    task automatic gen_frame();
        longint fb;
        for (int i = 0; i < OSR; i++) begin
            fb   = m_q ? FS : -FS;
            m_a1 = sat_iw(m_a1 + mx - fb);
            m_a2 = sat_iw(m_a2 + m_a1 - fb);
            m_q  = (m_a2 >= 0);
            exp_q.push_back('{b: m_q, f: (i == 0), x: mx});
        end
    endtask

    // Outputs are checked on the falling edge; the model then steps for the next rising edge.
    always @(negedge clk) begin
        if (chk_on) begin
            if (m_clr) begin
                cur_dout  = 1'b0;
                cur_frame = 1'b0;
                f_bits    = 0;
                prev_x    = -1;
            end else if (m_bv && exp_q.size() > 0) begin
                e         = exp_q.pop_front();
                cur_dout  = e.b;
                cur_frame = e.f;
            end else begin
                cur_frame = 1'b0;
            end
            check("bit_valid", bit_valid, m_bv);
            check("dout", dout, cur_dout);
            check("frame", frame, cur_frame);
            check("din_ready", din_ready,
                  (m_state == S_LOAD) || (m_state == S_RUN && mcnt == OSR - 1));
            check("clamp_flag", clamp_flag, m_clamp);
            check("underrun_flag", underrun_flag, m_under);
            if (m_bv) begin
                if (cur_frame) begin
                    if (f_bits == OSR && f_x == prev_x) begin
                        ctr = 128 + (f_x * 128) / FS;
                        $display("frame x=%0d ones=%0d", f_x, f_ones);
                        check("ones_in_range", (f_ones >= ctr - TOL) && (f_ones <= ctr + TOL), 1);
                    end
                    prev_x = (f_bits == OSR) ? f_x : -1;
                    f_x    = e.x;
                    f_bits = 0;
                    f_ones = 0;
                end
                f_bits++;
                f_ones += int'(dout);
            end
            a_now = dut.u_core.acc1_reg;
            if (a_now < 0) a_now = -a_now;
            if (a_now > a_peak) a_peak = a_now;
            a_now = dut.u_core.acc2_reg;
            if (a_now < 0) a_now = -a_now;
            if (a_now > a_peak) a_peak = a_now;
        end

        m_bv  = 1'b0;
        m_clr = 1'b0;
        if (rst) begin
            m_state = S_IDLE;
            mcnt    = 0;
            mx      = 0;
            m_clamp = 1'b0;
            m_under = 1'b0;
            m_clr   = 1'b1;
            chk_on  = 1'b1;
            exp_q.delete();
        end else begin
            m_ready = (m_state == S_LOAD) || (m_state == S_RUN && mcnt == OSR - 1);
            m_acc   = m_ready && din_valid;
            if (m_acc) begin
                mx = longint'($signed(din));
                if (mx > XMAX) begin
                    mx = XMAX;
                    m_clamp = 1'b1;
                end else if (mx < -XMAX) begin
                    mx = -XMAX;
                    m_clamp = 1'b1;
                end
                $display("accept din=%0d x=%0d", $signed(din), mx);
            end
            case (m_state)
                S_IDLE: begin
                    if (en) m_state = S_LOAD;
                    else m_clr = 1'b1;
                end
                S_LOAD: begin
                    if (!en) begin
                        m_state = S_IDLE;
                        m_clr   = 1'b1;
                    end else if (din_valid) begin
                        m_state = S_RUN;
                        mcnt    = 0;
                        gen_frame();
                    end
                end
                default: begin
                    if (!en) begin
                        m_state = S_IDLE;
                        m_clr   = 1'b1;
                        exp_q.delete();
                    end else begin
                        m_bv = 1'b1;
                        if (mcnt == OSR - 1) begin
                            mcnt = 0;
                            if (!din_valid) m_under = 1'b1;
                            gen_frame();
                        end else begin
                            mcnt++;
                        end
                    end
                end
            endcase
        end
        if (m_clr) begin
            m_a1 = 0;
            m_a2 = 0;
            m_q  = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * OSR + 4 && !seen; i++) begin
            @(negedge clk);
            if (din_ready && din_valid) seen = 1'b1;
        end
        check(tag, seen, 1);
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_ready", din_ready, 0);
        rst = 1'b0;
        tick(1);

        // Zero input: mid-scale density, LOAD shows ready before the first sample.
        en = 1'b1;
        tick(1);
        @(negedge clk);
        check("load_ready", din_ready, 1);
        din = 16'h0000; din_valid = 1'b1;
        tick(2 * OSR + 10);

        // Half scale, then over-range input that must be clamped.
        din = 16'h4000;
        tick(3 * OSR);
        din = 16'h7FFF;
        tick(2 * OSR + 20);
        @(negedge clk);
        check("x_clamped", dut.x_reg, 24576);
        check("clamp_sticky", clamp_flag, 1);
        check("no_underrun_yet", underrun_flag, 0);

        // Withhold the sample across one boundary; previous x keeps running.
        wait_accept("accept_before_gap");
        din_valid = 1'b0;
        din = 16'h2000;
        tick(OSR + 4);
        @(negedge clk);
        check("underrun_set", underrun_flag, 1);
        check("bit_valid_during_gap", bit_valid, 1);
        check("x_kept", dut.x_reg, 24576);
        din_valid = 1'b1;
        tick(2 * OSR);

        // Drop en mid-frame.
        tick(100);
        en = 1'b0;
        tick(1);
        @(negedge clk);
        check("en_off_bit_valid", bit_valid, 0);
        check("en_off_acc1", dut.u_core.acc1_reg, 0);
        check("en_off_acc2", dut.u_core.acc2_reg, 0);
        en = 1'b1;
        din = 16'h4000;
        tick(1);
        @(negedge clk);
        check("reload_ready", din_ready, 1);
        tick(OSR + 50);

        // Reset coincident with a boundary handshake.
        din = 16'h1000;
        hit = 1'b0;
        for (int i = 0; i < 2 * OSR + 4 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (din_ready && bit_valid) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        check("found_boundary", hit, 1);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_run_dout", dout, 0);
        check("rst_run_bit_valid", bit_valid, 0);
        check("rst_run_frame", frame, 0);
        check("rst_run_clamp", clamp_flag, 0);
        check("rst_run_underrun", underrun_flag, 0);
        check("rst_run_x", dut.x_reg, 0);
        tick(OSR + 20);

        @(negedge clk);
        check("no_saturation", a_peak < AMAX, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
